// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access controller.
//   DATA_W     : memory word width
//   CMD_ADDR_W : address field width inside a queued command (zero-extended word address)
//   state_e    : controller FSM states
//   cmd_t      : one queued request (write enable, address, write data)
package mem_ctrl_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CMD_ADDR_W = 32;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD_DATA
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
    } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Command FIFO for the memory access controller (not fall-through).
// Ports:
//   clk       : clock
//   reset_n   : synchronous active-low reset, flushes the FIFO
//   push      : write push_data (ignored when full)
//   push_data : command to enqueue
//   pop       : drop the head entry (ignored when empty)
//   pop_data  : current head entry
//   full      : no free entry
//   empty     : no valid entry
module mem_cmd_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    cmd_t           store_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_data = store_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            store_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response front end owning a single-port on-chip memory. After reset the whole
// memory is zero-filled (optional), then queued requests execute strictly in order.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake; req_we, req_addr, req_wdata describe the request
//   rsp_valid, rsp_rdata  : one-cycle read response pulse and its data
//   init_done             : zero-fill sweep finished
//   write, read           : monitor strobes (never both high)
//   wdata, rdata, addr    : monitor data/address, held when the strobes are low
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              write,
    output logic              read,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              init_go_q;
    logic              init_done_q;
    logic              exec_valid_q;
    cmd_t              exec_q;
    logic [DATA_W-1:0] rdata_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    cmd_t              fifo_in, fifo_head;
    logic              init_wr, exec_wr, exec_rd, rd_strobe;
    logic [ADDR_W-1:0] mem_idx;

    assign req_ready = init_done_q && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_in   = '{we: req_we, addr: CMD_ADDR_W'(req_addr), wdata: req_wdata};

    mem_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        init_wr   = 1'b0;
        exec_wr   = 1'b0;
        exec_rd   = 1'b0;
        rd_strobe = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            INIT: begin
                // init_go_q keeps the sweep quiet during the cycle right after a reset edge.
                if (init_go_q) begin
                    init_wr = 1'b1;
                    if (&init_cnt_q) begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (exec_valid_q && !exec_q.we) begin
                    exec_rd = 1'b1;
                    state_d = RD_DATA;
                end else begin
                    // A write finishes this cycle, so the next command can load on the same edge.
                    exec_wr  = exec_valid_q;
                    fifo_pop = !fifo_empty;
                end
            end
            RD_DATA: begin
                rd_strobe = 1'b1;
                fifo_pop  = !fifo_empty;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr  = addr_q;
        wdata = wdata_q;
        if (init_wr) begin
            addr  = 32'(init_cnt_q);
            wdata = '0;
        end else if (exec_wr) begin
            addr  = exec_q.addr;
            wdata = exec_q.wdata;
        end else if (rd_strobe) begin
            addr  = exec_q.addr;
        end
    end

    assign write     = init_wr || exec_wr;
    assign read      = rd_strobe;
    assign rsp_valid = rd_strobe;
    assign rsp_rdata = rdata_q;
    assign rdata     = rdata_q;
    assign init_done = init_done_q;
    assign mem_idx   = init_wr ? init_cnt_q : exec_q.addr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= INIT_ON_RESET ? INIT : IDLE;
            init_done_q  <= !INIT_ON_RESET;
            init_go_q    <= 1'b0;
            init_cnt_q   <= '0;
            exec_valid_q <= 1'b0;
            exec_q       <= '0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q   <= state_d;
            init_go_q <= 1'b1;
            addr_q    <= addr;
            wdata_q   <= wdata;
            if (init_wr) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (&init_cnt_q) begin
                    init_done_q <= 1'b1;
                end
            end
            if (fifo_pop) begin
                exec_valid_q <= 1'b1;
                exec_q       <= fifo_head;
            end else if (exec_wr || rd_strobe) begin
                exec_valid_q <= 1'b0;
            end
            if (exec_rd) begin
                rdata_q <= mem_q[exec_q.addr[ADDR_W-1:0]];
            end
        end
    end

    // Storage has no reset; the INIT sweep provides known contents.
    always_ff @(posedge clk) begin
        if (reset_n && write) begin
            mem_q[mem_idx] <= init_wr ? '0 : exec_q.wdata;
        end
    end

endmodule
